// File: rtl/sirv_uart_autobaud_pkg.sv
// Shared UART definitions: autobaud FSM encoding, UART reset divisor and the
// calibration character used for bit-time measurement.
package sirv_uart_autobaud_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } ab_state_t;

  localparam logic [15:0] UART_DIV_RESET = 16'h21e;
  localparam logic [7:0]  CAL_CHAR       = 8'h55;

  // 0x55 LSB first gives falling edges at start, b1, b3, b5, b7: 8 bit times apart
  localparam int unsigned CAL_FALL_EDGES = 5;

endpackage

// File: rtl/sirv_sync_bit.sv
// Multi-flop single-bit synchroniser with a configurable reset value.
module sirv_sync_bit #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_chain <= {STAGES{RESET_VAL}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/sirv_uart_autobaud.sv
// UART receive front end: synchronises rxd and, on request, measures the bit
// time of a 0x55 calibration character to produce a UART divisor.
module sirv_uart_autobaud
  import sirv_uart_autobaud_pkg::*;
#(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_DIV     = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_en,
  input  logic             io_rxd_pin,
  output logic             io_rxd_out,
  input  logic             io_start,
  output logic             io_busy,
  output logic             io_done,
  output logic             io_err,
  output logic [DIV_W-1:0] io_div,
  output logic             io_div_valid
);

  localparam int unsigned CW = DIV_W + 3;

  logic             w_rxd;
  logic             w_fe;
  logic             w_sat;
  logic [CW:0]      w_sum;
  logic [DIV_W-1:0] w_div_new;

  ab_state_t        r_state, w_state_nxt;
  logic             r_rxd_d;
  logic [CW-1:0]    r_cyc, w_cyc_nxt;
  logic [2:0]       r_edge, w_edge_nxt;
  logic             r_idle, w_idle_nxt;
  logic             r_err, w_err_nxt;
  logic             r_done, w_done_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic             r_div_valid, w_div_valid_nxt;

  sirv_sync_bit #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .i_d  (io_rxd_pin),
    .o_q  (w_rxd)
  );

  assign io_rxd_out = w_rxd;
  assign w_fe       = r_rxd_d & ~w_rxd;
  assign w_sat      = &r_cyc;
  // Extra headroom bit so the rounding add cannot wrap near saturation
  assign w_sum      = {1'b0, r_cyc} + (CW+1)'(4);
  assign w_div_new  = DIV_W'((w_sum >> 3) - (CW+1)'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rxd_d     <= 1'b1;
      r_cyc       <= '0;
      r_edge      <= '0;
      r_idle      <= 1'b0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
      r_div       <= DIV_W'(UART_DIV_RESET);
      r_div_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rxd_d     <= w_rxd;
      r_cyc       <= w_cyc_nxt;
      r_edge      <= w_edge_nxt;
      r_idle      <= w_idle_nxt;
      r_err       <= w_err_nxt;
      r_done      <= w_done_nxt;
      r_div       <= w_div_nxt;
      r_div_valid <= w_div_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cyc_nxt       = r_cyc;
    w_edge_nxt      = r_edge;
    w_idle_nxt      = r_idle;
    w_err_nxt       = r_err;
    w_done_nxt      = 1'b0;
    w_div_nxt       = r_div;
    w_div_valid_nxt = r_div_valid;

    if (!io_en) begin
      w_state_nxt = IDLE;
    end else if (io_start) begin
      w_state_nxt = ARM;
      w_cyc_nxt   = '0;
      w_edge_nxt  = '0;
      w_idle_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
    end else begin
      case (r_state)
        IDLE: ;
        ARM: begin
          if (w_rxd) w_idle_nxt = 1'b1;
          // Only accept the start edge once the line has been seen idle while armed
          if (r_idle && w_fe) begin
            w_state_nxt = MEAS;
            w_cyc_nxt   = CW'(1);
            w_edge_nxt  = 3'd1;
          end
        end
        MEAS: begin
          if (w_sat) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = IDLE;
          end else if (w_fe && (r_edge == 3'(CAL_FALL_EDGES - 1))) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
            if (w_div_new < DIV_W'(MIN_DIV)) begin
              w_err_nxt = 1'b1;
            end else begin
              w_div_nxt       = w_div_new;
              w_div_valid_nxt = 1'b1;
            end
          end else begin
            w_cyc_nxt = r_cyc + CW'(1);
            if (w_fe) w_edge_nxt = r_edge + 3'd1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign io_busy      = (r_state != IDLE);
  assign io_done      = r_done;
  assign io_err       = r_err;
  assign io_div       = r_div;
  assign io_div_valid = r_div_valid;

endmodule

// File: tb/tb_sirv_uart_autobaud.sv
// Scoreboard bench for sirv_uart_autobaud: expected measurement results are
// queued by the stimulus and checked by a monitor on each io_done pulse.
module tb_sirv_uart_autobaud;
  import sirv_uart_autobaud_pkg::*;

  typedef struct {
    int div;
    int err;
    int valid;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b1;
  logic        pin = 1'b1;
  logic        start = 1'b0;
  logic        rxd_out, busy, done, err, div_valid;
  logic [15:0] div;

  logic        s_en = 1'b1;
  logic        s_pin = 1'b1;
  logic        s_start = 1'b0;
  logic        s_rxd_out, s_busy, s_done, s_err, s_div_valid;
  logic [7:0]  s_div;

  int   total = 0;
  int   bad = 0;
  int   s_done_cnt = 0;
  exp_t exp_q[$];
  int   j0[11] = '{default: 0};
  int   jj[11] = '{2, -1, 1, -2, 2, 1, -1, 2, -2, 0, 0};

  always #5 clock = ~clock;

  sirv_uart_autobaud #(.DIV_W(16), .SYNC_STAGES(2), .MIN_DIV(15)) u_dut (
    .clock(clock), .reset(reset), .io_en(en), .io_rxd_pin(pin),
    .io_rxd_out(rxd_out), .io_start(start), .io_busy(busy), .io_done(done),
    .io_err(err), .io_div(div), .io_div_valid(div_valid)
  );

  // Narrow counter instance so saturation is reachable in a short run
  sirv_uart_autobaud #(.DIV_W(8), .SYNC_STAGES(2), .MIN_DIV(15)) u_sat (
    .clock(clock), .reset(reset), .io_en(s_en), .io_rxd_pin(s_pin),
    .io_rxd_out(s_rxd_out), .io_start(s_start), .io_busy(s_busy), .io_done(s_done),
    .io_err(s_err), .io_div(s_div), .io_div_valid(s_div_valid)
  );

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_div", int'(div), e.div);
        chk("done_err", int'(err), e.err);
        chk("done_valid", int'(div_valid), e.valid);
      end
    end
    if (!reset && s_done) s_done_cnt++;
  end

  task automatic push_exp(input int d, input int e, input int v);
    exp_t x;
    x.div = d; x.err = e; x.valid = v;
    exp_q.push_back(x);
  endtask

  task automatic start_pulse();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    repeat (5) @(negedge clock);
  endtask

  task automatic send_char(input int bt, input int jit[11], input int nbits);
    logic [9:0] frame;
    frame = {1'b1, CAL_CHAR, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      pin = frame[i];
      repeat (bt + jit[i+1] - jit[i]) @(negedge clock);
    end
    pin = 1'b1;
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clock);
    end
    chk("drain_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #1 reset = 1'b1;
    @(negedge clock);
    chk("rst_rxd_out", int'(rxd_out), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_valid", int'(div_valid), 0);
    chk("rst_div", int'(div), 16'h21e);
    @(negedge clock) reset = 1'b0;
    repeat (3) @(negedge clock);

    // start while disabled must not arm
    en = 1'b0; start = 1'b1;
    @(negedge clock) start = 1'b0;
    chk("start_en_low_busy", int'(busy), 0);
    en = 1'b1;
    repeat (3) @(negedge clock);

    // nominal UART rate: 543 clocks per bit
    push_exp(16'h21e, 0, 1);
    start_pulse();
    chk("armed_busy", int'(busy), 1);
    send_char(543, j0, 10);
    wait_drain(2000);
    chk("t1_busy_after", int'(busy), 0);

    // 100 clocks per bit with edge jitter; span 796 rounds to 100 -> div 99
    push_exp(99, 0, 1);
    start_pulse();
    send_char(100, jj, 10);
    wait_drain(2000);

    // too fast: result 7 < MIN_DIV, divisor keeps 99
    push_exp(99, 1, 1);
    start_pulse();
    send_char(8, j0, 10);
    wait_drain(2000);

    // abort after third falling edge via io_en
    start_pulse();
    chk("start_clears_err", int'(err), 0);
    send_char(543, j0, 4);
    pin = 1'b0;
    repeat (10) @(negedge clock);
    chk("abort_busy_before", int'(busy), 1);
    en = 1'b0;
    @(posedge clock) #1;
    chk("abort_busy", int'(busy), 0);
    @(negedge clock) begin pin = 1'b1; en = 1'b1; end
    repeat (20) @(negedge clock);
    chk("abort_div_held", int'(div), 99);
    push_exp(16'h21e, 0, 1);
    start_pulse();
    send_char(543, j0, 10);
    wait_drain(2000);

    // reset in the middle of a measurement
    start_pulse();
    send_char(543, j0, 3);
    chk("pre_reset_busy", int'(busy), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_div", int'(div), 16'h21e);
    chk("mid_rst_valid", int'(div_valid), 0);
    chk("mid_rst_rxd", int'(rxd_out), 1);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    // synchroniser latency: two clocks
    pin = 1'b0;
    @(posedge clock) #1 chk("sync_fall_1", int'(rxd_out), 1);
    @(posedge clock) #1 chk("sync_fall_2", int'(rxd_out), 0);
    @(negedge clock) pin = 1'b1;
    @(posedge clock) #1 chk("sync_rise_1", int'(rxd_out), 0);
    @(posedge clock) #1 chk("sync_rise_2", int'(rxd_out), 1);

    // cycle counter saturation on the 8-bit instance (11-bit counter)
    @(negedge clock) s_start = 1'b1;
    @(negedge clock) s_start = 1'b0;
    repeat (5) @(negedge clock);
    s_pin = 1'b0;
    repeat (3) @(negedge clock);
    s_pin = 1'b1;
    repeat (10) @(negedge clock);
    chk("sat_busy_meas", int'(s_busy), 1);
    repeat (2100) @(negedge clock);
    chk("sat_err", int'(s_err), 1);
    chk("sat_busy", int'(s_busy), 0);
    chk("sat_no_done", s_done_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
